eth_mac_tx: RTL and testbench
=============================

# eth_mac_tx

MAC-side transmit framer that drives the PHY's 8-bit transmit interface (txen/txd). It accepts a payload byte stream (destination MAC through end of payload) with a valid/ready/last handshake. Around that payload it emits preamble, SFD, zero padding to minimum length, the CRC-32 FCS, and the inter-frame gap. It is the producer the PHY transmitter consumes: one byte per clock, GMII-style.

## Interface
- MIN_LEN, 60: minimum payload+header byte count before FCS; shorter frames are zero-padded.
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD.
- IFG_CYCLES, 12: idle cycles (txen low) after the last FCS byte.
- in_clk  input  1  transmit clock, one byte per cycle.
- in_rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_last  input  1  marks the final payload byte of the frame.
- out_ready  output  1  framer accepts in_data this cycle.
- out_txen  output  1  to PHY in_txen.
- out_txd  output  8  to PHY in_txd.
- out_txer  output  1  transmit error, marks an aborted frame.
- out_busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, ERR, IFG.
- IDLE: out_txen=0. A cycle with in_valid=1 starts the frame (the byte is not consumed) and moves to PRE.
- PRE: PREAMBLE_LEN cycles of out_txd=0x55, txen=1. Then go to SFD.
- SFD: one cycle of out_txd=0xD5, txen=1. Then go to DATA.
- out_ready = 1 in SFD and in DATA until the in_last byte has been accepted. A byte is accepted on in_valid & out_ready.
- DATA: each accepted byte appears on out_txd the next cycle and is fed to the CRC. Byte counter is 11 bits and saturates at 2047.
- After the last byte:
  - If count < MIN_LEN, go to PAD, which emits 0x00 (fed to the CRC) until count == MIN_LEN.
  - Otherwise go to FCS.
- FCS: 4 bytes of ~crc, LSB first. CRC-32 uses reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per byte. Then go to IFG.
- Underrun: out_ready=1 and in_valid=0 in SFD or DATA aborts the frame:
  - Next cycle is ERR: txen=1, txer=1, txd=0x00 for one cycle.
  - Then go to IFG.
  - The upstream must drop the remainder of the frame.
- IFG: IFG_CYCLES cycles of txen=0, then IDLE. in_valid is ignored during IFG.
- No oversize check: frames longer than 1514 bytes are transmitted as given.

## Timing
- All outputs are registered except out_ready, which is decoded from the state register.
- Reset (in_rst_n=0 at a clock edge) forces:
  - state to IDLE and all counters to 0;
  - out_txen=0, out_txd=0x00, out_txer=0, out_busy=0, out_ready=0.
- Reset mid-frame truncates the frame immediately; no FCS and no IFG are sent.
- Start latency: in_valid high in IDLE at cycle 0 gives txen=1 at cycle 1. Preamble occupies cycles 1..PREAMBLE_LEN, SFD is at PREAMBLE_LEN+1, and the first data byte is at PREAMBLE_LEN+2.
- out_txen stays high continuously from the first preamble byte to the last FCS byte (or the ERR cycle).
- Frame on-wire length is PREAMBLE_LEN + 1 + max(N, MIN_LEN) + 4 cycles.
- Back-to-back frames: with in_valid held high, the next preamble starts exactly IFG_CYCLES+1 cycles after the last FCS byte. That is IFG_CYCLES idle cycles plus one IDLE cycle.
- in_last on a byte that completes exactly MIN_LEN bytes goes directly to FCS with no PAD cycle.
- in_last on the SFD-cycle handshake (1-byte frame) is legal.

## Structure
- Shared package eth_pkg holds:
  - state enum;
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5;
  - CRC_POLY=32'hEDB88320 and CRC_INIT=32'hFFFFFFFF;
  - default MIN_LEN and IFG_CYCLES.
- Sub-module crc32_d8 is combinational: next CRC from the current CRC and a data byte. The CRC register lives in eth_mac_tx and is reset to CRC_INIT in IDLE.
- The same crc32_d8 is reused by the future MAC receiver.

## Test plan
- MIN_LEN=0, payload ASCII "123456789" → 7×0x55, 0xD5, 31..39, then FCS bytes 26 39 F4 CB. txen is high for 21 cycles.
- Default MIN_LEN, 1-byte frame 0xAB → 0xAB followed by 59×0x00 and a correct FCS. txen is high for 72 cycles and out_ready is high for exactly 1 cycle.
- 64-byte frame with upstream in_valid held high and two frames queued → between the first frame's last FCS byte and the next 0x55 there are exactly 12 txen-low cycles plus 1 IDLE cycle.
- Underrun: in_valid drops after the 10th accepted byte → next cycle txen=1, txer=1, txd=0x00, then 12 txen-low cycles, no FCS, back to IDLE.
- in_rst_n pulled low during PAD → next cycle all outputs are 0. A new frame started afterwards is transmitted with a correct FCS.
- Upstream throttling: in_valid gated only when out_ready=0 → byte order is preserved and no gap appears on txen.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: transmit FSM states, framing bytes,
// CRC-32 constants and default framing parameters.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_ERR  = 3'd6,
    ST_IFG  = 3'd7
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  localparam int DEFAULT_MIN_LEN      = 60;
  localparam int DEFAULT_PREAMBLE_LEN = 7;
  localparam int DEFAULT_IFG_CYCLES   = 12;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected, 0xEDB88320) advance by one data byte.
// Shared by the MAC transmitter and receiver; the CRC register lives in the caller.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/eth_mac_tx.sv
// GMII-style transmit framer: preamble, SFD, payload, zero pad, FCS, IFG.
// Handshake: a byte is accepted on a cycle where in_valid && out_ready.
module eth_mac_tx
  import eth_pkg::*;
#(
  parameter int MIN_LEN      = DEFAULT_MIN_LEN,
  parameter int PREAMBLE_LEN = DEFAULT_PREAMBLE_LEN,
  parameter int IFG_CYCLES   = DEFAULT_IFG_CYCLES
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_ready,
  output logic       out_txen,
  output logic [7:0] out_txd,
  output logic       out_txer,
  output logic       out_busy,
  output tx_state_t  out_state
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [7:0]  FCS_LAST = 8'd3;

  tx_state_t   state, state_n;
  logic [10:0] byte_cnt, byte_cnt_n, byte_cnt_inc;
  logic [7:0]  phase_cnt, phase_cnt_n;
  logic        last_seen, last_seen_n;
  logic [31:0] crc, crc_n, crc_upd;
  logic [7:0]  crc_byte;
  logic        txen_n, txer_n;
  logic [7:0]  txd_n;
  logic        accept, underrun;

  // Ready drops once the in_last byte is taken, while that byte is still on the wire.
  assign out_ready    = ((state == ST_SFD) || (state == ST_DATA)) && !last_seen;
  assign accept       = out_ready && in_valid;
  assign underrun     = out_ready && !in_valid;
  assign out_state    = state;
  assign crc_byte     = accept ? in_data : 8'h00;
  assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (crc_byte),
    .crc_next (crc_upd)
  );

  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    phase_cnt_n = phase_cnt;
    last_seen_n = last_seen;
    crc_n       = crc;
    txen_n      = 1'b0;
    txer_n      = 1'b0;
    txd_n       = 8'h00;
    case (state)
      ST_IDLE: begin
        byte_cnt_n  = 11'd0;
        phase_cnt_n = 8'd0;
        last_seen_n = 1'b0;
        crc_n       = CRC_INIT;
        if (in_valid) begin
          state_n = ST_PRE;
          txen_n  = 1'b1;
          txd_n   = PREAMBLE_BYTE;
        end
      end
      ST_PRE: begin
        txen_n = 1'b1;
        if (phase_cnt == PRE_LAST) begin
          state_n = ST_SFD;
          txd_n   = SFD_BYTE;
        end else begin
          phase_cnt_n = phase_cnt + 8'd1;
          txd_n       = PREAMBLE_BYTE;
        end
      end
      ST_SFD, ST_DATA, ST_PAD: begin
        txen_n = 1'b1;
        if (underrun) begin
          state_n = ST_ERR;
          txer_n  = 1'b1;
        end else if (accept) begin
          state_n     = ST_DATA;
          txd_n       = in_data;
          crc_n       = crc_upd;
          byte_cnt_n  = byte_cnt_inc;
          last_seen_n = in_last;
        end else if (byte_cnt < MIN_CNT) begin
          // Payload finished short: keep emitting zeros into the CRC.
          state_n    = ST_PAD;
          crc_n      = crc_upd;
          byte_cnt_n = byte_cnt_inc;
        end else begin
          state_n     = ST_FCS;
          phase_cnt_n = 8'd0;
          txd_n       = ~crc[7:0];
        end
      end
      ST_FCS: begin
        if (phase_cnt == FCS_LAST) begin
          state_n     = ST_IFG;
          phase_cnt_n = 8'd0;
        end else begin
          // The CRC register is consumed LSB first by shifting it down.
          txen_n      = 1'b1;
          txd_n       = ~crc[15:8];
          crc_n       = {8'hFF, crc[31:8]};
          phase_cnt_n = phase_cnt + 8'd1;
        end
      end
      ST_ERR: begin
        state_n     = ST_IFG;
        phase_cnt_n = 8'd0;
      end
      ST_IFG: begin
        if (phase_cnt == IFG_LAST) begin
          state_n = ST_IDLE;
        end else begin
          phase_cnt_n = phase_cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= 11'd0;
      phase_cnt <= 8'd0;
      last_seen <= 1'b0;
      crc       <= CRC_INIT;
      out_txen  <= 1'b0;
      out_txd   <= 8'h00;
      out_txer  <= 1'b0;
      out_busy  <= 1'b0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      phase_cnt <= phase_cnt_n;
      last_seen <= last_seen_n;
      crc       <= crc_n;
      out_txen  <= txen_n;
      out_txd   <= txd_n;
      out_txer  <= txer_n;
      out_busy  <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Directed bench for eth_mac_tx: two instances (MIN_LEN=0 and default) share
// the upstream inputs; wire traces are recorded per cycle and scored against expected bytes.
module tb_eth_mac_tx;
  import eth_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last;
  logic [7:0] in_data;

  logic       ready, txen, txer, busy;
  logic [7:0] txd;
  tx_state_t  state;
  logic       ready0, txen0, txer0, busy0;
  logic [7:0] txd0;
  tx_state_t  state0;

  always #5 clk = ~clk;

  eth_mac_tx dut (
    .in_clk (clk), .in_rst_n (rst_n), .in_valid (in_valid), .in_data (in_data),
    .in_last (in_last), .out_ready (ready), .out_txen (txen), .out_txd (txd),
    .out_txer (txer), .out_busy (busy), .out_state (state)
  );

  eth_mac_tx #(.MIN_LEN(0)) dut0 (
    .in_clk (clk), .in_rst_n (rst_n), .in_valid (in_valid), .in_data (in_data),
    .in_last (in_last), .out_ready (ready0), .out_txen (txen0), .out_txd (txd0),
    .out_txer (txer0), .out_busy (busy0), .out_state (state0)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  frame_q[$];
  logic        last_q[$];
  // trace entry: {busy, txen, txer, ready, txd}
  logic [11:0] tr_q[$];
  logic [11:0] tr0_q[$];
  bit          rec = 0;
  int          n_txen, n_ready, n_txer, first_en, last_en;

  always @(negedge clk) begin
    if (rec) begin
      tr_q.push_back({busy, txen, txer, ready, txd});
      tr0_q.push_back({busy0, txen0, txer0, ready0, txd0});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_exp(input int min_len);
    logic [7:0]  body[$];
    logic [31:0] f;
    body = pay_q;
    while (body.size() < min_len) body.push_back(8'h00);
    f = ref_fcs(body);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
  endtask

  task automatic load_single();
    frame_q = pay_q;
    last_q.delete();
    for (int i = 0; i < pay_q.size(); i++) last_q.push_back(i == pay_q.size() - 1);
  endtask

  task automatic extract(input bit use0);
    logic [11:0] t[$];
    if (use0) t = tr0_q; else t = tr_q;
    got_q.delete();
    n_txen = 0; n_ready = 0; n_txer = 0; first_en = -1; last_en = -1;
    foreach (t[i]) begin
      if (t[i][10]) begin
        got_q.push_back(t[i][7:0]);
        n_txen++;
        if (first_en < 0) first_en = i;
        last_en = i;
      end
      if (t[i][8]) n_ready++;
      if (t[i][9]) n_txer++;
    end
  endtask

  task automatic compare_stream(input string tag);
    logic [7:0] e, g;
    int k;
    k = 0;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check($sformatf("%s_b%0d", tag, k), 32'(g), 32'(e));
      k++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- driver ----------------
  // stop_after < 0 sends the whole frame_q; otherwise valid drops after that many accepts.
  task automatic drive(input int stop_after, input bit throttle);
    int idx, acc, guard, target;
    bit started, rdy;
    idx = 0; acc = 0; guard = 0; started = 0;
    target = (stop_after >= 0) ? stop_after : frame_q.size();
    @(negedge clk);
    while (idx < frame_q.size() && acc != stop_after && guard < 5000) begin
      if (txen) started = 1;
      in_data  = frame_q[idx];
      in_last  = last_q[idx];
      in_valid = (throttle && started && !ready) ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy      = ready;
      @(negedge clk);
      if (in_valid && rdy) begin
        idx++;
        acc++;
      end
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    check("drive_accepted", 32'(acc), 32'(target));
  endtask

  task automatic start_rec();
    @(posedge clk);
    #1;
    tr_q.delete();
    tr0_q.delete();
    rec = 1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || busy0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy | busy0), 32'd0);
    repeat (2) @(negedge clk);
    rec = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e1, s2, j, low;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txen", 32'(txen), 32'd0);
    check("rst_txd", 32'(txd), 32'd0);
    check("rst_txer", 32'(txer), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: MIN_LEN=0, "123456789" -> FCS 26 39 F4 CB
    pay_q.delete();
    for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
    load_single();
    start_rec();
    drive(-1, 1'b0);
    wait_idle("t1");
    extract(1'b1);
    check("t1_start", 32'({tr0_q[0][10], tr0_q[1][10]}), 32'b01);
    check("t1_txen_cycles", 32'(n_txen), 32'd21);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
    exp_q.push_back(8'h26); exp_q.push_back(8'h39);
    exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    compare_stream("t1");

    // T2: 1-byte frame 0xAB padded to 60
    pay_q.delete();
    pay_q.push_back(8'hAB);
    load_single();
    start_rec();
    drive(-1, 1'b0);
    wait_idle("t2");
    extract(1'b0);
    check("t2_txen_cycles", 32'(n_txen), 32'd72);
    check("t2_contig", 32'(last_en - first_en + 1), 32'd72);
    check("t2_ready_cycles", 32'(n_ready), 32'd1);
    build_exp(60);
    compare_stream("t2");

    // T3: two 64-byte frames back to back, in_valid held high
    frame_q.delete(); last_q.delete();
    for (int i = 0; i < 128; i++) begin
      frame_q.push_back((i < 64) ? 8'(i * 7 + 3) : (8'(i) ^ 8'hA5));
      last_q.push_back(i == 63 || i == 127);
    end
    start_rec();
    drive(-1, 1'b0);
    wait_idle("t3");
    extract(1'b0);
    e1 = first_en;
    while (e1 + 1 < tr_q.size() && tr_q[e1 + 1][10]) e1++;
    s2 = e1 + 1;
    while (s2 < tr_q.size() && !tr_q[s2][10]) s2++;
    check("t3_gap", 32'(s2 - e1 - 1), 32'd13);
    check("t3_idle_before_pre", 32'(tr_q[s2 - 1][11]), 32'd0);
    check("t3_run1", 32'(e1 - first_en + 1), 32'd76);
    check("t3_run2", 32'(last_en - s2 + 1), 32'd76);
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(frame_q[i]);
    build_exp(60);
    pay_q.delete();
    for (int i = 64; i < 128; i++) pay_q.push_back(frame_q[i]);
    build_exp(60);
    compare_stream("t3");

    // T4: underrun after the 10th accepted byte
    pay_q.delete();
    for (int i = 0; i < 20; i++) pay_q.push_back(8'hC0 + 8'(i));
    load_single();
    start_rec();
    drive(10, 1'b0);
    wait_idle("t4");
    extract(1'b0);
    check("t4_txen_cycles", 32'(n_txen), 32'd19);
    check("t4_txer_cycles", 32'(n_txer), 32'd1);
    check("t4_txer_at_end", 32'(tr_q[last_en][9]), 32'd1);
    low = 0;
    j = last_en + 1;
    while (j < tr_q.size() && tr_q[j][11] && !tr_q[j][10]) begin
      low++;
      j++;
    end
    check("t4_ifg_cycles", 32'(low), 32'd12);
    check("t4_back_idle", 32'(tr_q[last_en + 13][11]), 32'd0);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'hC0 + 8'(i));
    exp_q.push_back(8'h00);
    compare_stream("t4");

    // T5: reset during PAD, then a clean 3-byte frame
    pay_q.delete();
    pay_q.push_back(8'h5A);
    load_single();
    drive(-1, 1'b0);
    repeat (10) @(negedge clk);
    check("t5_in_pad", 32'(state), 32'(ST_PAD));
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_txen", 32'(txen), 32'd0);
    check("t5_rst_txd", 32'(txd), 32'd0);
    check("t5_rst_txer", 32'(txer), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pay_q.delete();
    pay_q.push_back(8'h01); pay_q.push_back(8'hFE); pay_q.push_back(8'h80);
    load_single();
    start_rec();
    drive(-1, 1'b0);
    wait_idle("t5");
    extract(1'b0);
    check("t5_txen_cycles", 32'(n_txen), 32'd72);
    build_exp(60);
    compare_stream("t5");

    // T6: 70-byte frame, valid randomly gated while ready is low
    pay_q.delete();
    for (int i = 0; i < 70; i++) pay_q.push_back(8'(i * 13 + 1));
    load_single();
    start_rec();
    drive(-1, 1'b1);
    wait_idle("t6");
    extract(1'b0);
    check("t6_txen_cycles", 32'(n_txen), 32'd82);
    check("t6_contig", 32'(last_en - first_en + 1), 32'd82);
    build_exp(60);
    compare_stream("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
